fixed_point_mean_square: RTL
============================

Name: fixed_point_mean_square

Overview:
Streaming mean-square accumulator that sits directly upstream of pipe_FixedPointSqrt, forming an RMS datapath.
- Accepts signed fixed-point samples over a valid/ready handshake.
- Squares and sums each block of 2^LOG2N samples.
- Emits the block mean square in the sqrt stage's WOI.WOF input format, saturated, with upflow/downflow flags.

Parameters:
WI, 8, integer bits of input sample (signed, incl. sign)
WF, 8, fractional bits of input sample
WOI, 9, integer bits of output (matches sqrt WII)
WOF, 10, fractional bits of output (matches sqrt WIF)
LOG2N, 2, log2 of block length N
ROUND, 1, 1 = round-half-up on fractional truncation, 0 = truncate

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
clr  in  1  synchronous block abort
in_valid  in  1  sample valid
in_ready  out  1  block can accept a sample
in_data  in  WI+WF  signed sample
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  WOI+WOF  signed mean square, always >= 0
upflow  out  1  result saturated, qualified by out_valid
downflow  out  1  nonzero mean rounded to zero, qualified by out_valid

Behaviour:
- Reset (rst=0, async):
  - State ACC; count, accumulator and square-valid flag cleared.
  - out_valid=0, out_data=0, upflow=0, downflow=0.
  - in_ready=1 once reset is released.
- Sample accept: when in_valid && in_ready.
- Pipeline:
  - Stage 1 registers the square of the accepted sample: 2*(WI+WF) bits, 2*WF fractional bits.
  - Stage 2 adds the stage-1 square into the accumulator, width 2*(WI+WF)+LOG2N (no internal overflow possible).
- States:
  - ACC: in_ready=1. Each accept increments count. The accept that makes count reach N goes to DRAIN.
  - DRAIN (exactly 1 cycle): in_ready=0. At the clock edge ending DRAIN, out_data/upflow/downflow are loaded, computed from accumulator + last square. Then go to HOLD.
  - HOLD: out_valid=1, in_ready=0, outputs stable. When out_ready=1, go to ACC on the next edge with accumulator and count cleared; in_ready returns the cycle after the handshake.
- Latency: out_valid rises 2 cycles after the cycle the Nth sample is accepted.
- Throughput: at best N+2 cycles per block; no overlap between blocks.
- Conversion:
  - mean = sum >> LOG2N.
  - Rescale from 2*WF to WOF fractional bits. If WOF < 2*WF, drop bits; with ROUND=1, add half an LSB first.
  - Saturate if mean > 2^(WOI-1) - 2^-WOF: out = 0 followed by all 1s, upflow=1.
  - downflow=1 iff sum != 0 and the converted result is 0.
- clr=1:
  - Forces state ACC next cycle; clears count, accumulator and square-valid flag; deasserts out_valid.
  - A sample presented in the same cycle is discarded.
  - clr has priority over all handshakes.
- Squaring the most negative input (-2^(WI-1)) is exact; no special case.

Optional Feature:
Macro FIXED_POINT_MEAN_SQUARE_PEAK_EN.
- Defined:
  - Adds output out_peak, WI+WF bits: the maximum |in_data| over the block.
  - |most negative| saturates to the max positive value.
  - Latched with out_data, held during HOLD, reset/cleared to 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package fixed_point_pkg:
  - state enum (ACC, DRAIN, HOLD);
  - function for the accumulator-width constant;
  - saturating rescale function (shift, round, clamp, flags), reusable by other fixed-point blocks.
- One natural sub-module, fixed_point_square_reg: the registered signed squarer (stage 1).

Test Plan:
Defaults throughout (WI=8, WF=8, WOI=9, WOF=10, N=4, ROUND=1), out_ready=1 unless stated.
- 0x0100 (1.0) x4 -> out_data=0x00400 two cycles after 4th accept; upflow=0, downflow=0.
- 0x0200, 0xFE00, 0x0200, 0xFE00 (±2.0) -> out_data=0x01000 (4.0); flags 0.
- 0x8000 (-128.0) x4 -> mean 16384 > 255.999; out_data=0x3FFFF, upflow=1.
- 0x0001 x4 -> mean 2^-16 rounds to 0; out_data=0, downflow=1.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles in HOLD.
  - Response: out_valid, out_data and flags stable; in_ready=0; in_valid pulses ignored. Handshake then releases and the next block starts.
- Abort and reset:
  - clr after 2 of 4 samples (3.0 each), then 4 samples of 1.0 -> out_data=0x00400.
  - rst low mid-DRAIN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// -----------------------------------------------------------------------------
// fixed_point_pkg
//   Shared types and helpers for the fixed-point datapath blocks.
//   - state_t     : control states of the mean-square accumulator
//   - acc_width() : accumulator width that cannot overflow for a block of 2^log2n squares
//   - sat_rescale(): mean + fractional rescale + round + clamp, with upflow/downflow flags
// -----------------------------------------------------------------------------
package fixed_point_pkg;

  typedef enum logic [1:0] {
    ST_ACC,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic [63:0] data;
    logic        upflow;
    logic        downflow;
  } rescale_t;

  function automatic int unsigned acc_width(input int unsigned wi,
                                            input int unsigned wf,
                                            input int unsigned log2n);
    return 2 * (wi + wf) + log2n;
  endfunction

  // sum is a non-negative value with in_frac fractional bits. It is divided by
  // 2^shift (truncating), then converted to an unsigned out_int.out_frac value
  // whose top (sign) bit is always 0. Saturation is decided on the exact mean so
  // a value just above the ceiling that would round down to it still flags.
  function automatic rescale_t sat_rescale(input logic [63:0] sum,
                                           input int unsigned shift,
                                           input int unsigned in_frac,
                                           input int unsigned out_int,
                                           input int unsigned out_frac,
                                           input logic        do_round);
    rescale_t    r;
    logic [63:0] mean;
    logic [63:0] conv;
    logic [63:0] max_out;
    int unsigned d;
    r       = '0;
    mean    = sum >> shift;
    max_out = (64'd1 << (out_int + out_frac - 1)) - 64'd1;
    if (out_frac < in_frac) begin
      d    = in_frac - out_frac;
      conv = mean;
      if (do_round) conv = conv + (64'd1 << (d - 1));
      conv     = conv >> d;
      r.upflow = (mean > (max_out << d));
    end else begin
      d        = out_frac - in_frac;
      conv     = mean << d;
      r.upflow = (conv > max_out);
    end
    if (conv > max_out) r.upflow = 1'b1;
    r.data     = r.upflow ? max_out : conv;
    r.downflow = (sum != '0) && (conv == '0);
    return r;
  endfunction

endpackage

// File: rtl/fixed_point_square_reg.sv
// -----------------------------------------------------------------------------
// fixed_point_square_reg
//   Registered signed squarer (first pipeline stage). The square of a signed
//   W-bit value is non-negative and fits 2*W bits, including -2^(W-1).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear of the valid flag and square
//   i_en       : accept i_data this cycle
//   i_data     : signed sample
//   o_sq       : registered square (unsigned, 2*W bits)
//   o_vld      : o_sq holds a square not yet consumed
// -----------------------------------------------------------------------------
module fixed_point_square_reg #(
  parameter int unsigned W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [W-1:0]     i_data,
  output logic [2*W-1:0]   o_sq,
  output logic             o_vld
);

  logic signed [2*W-1:0] w_prod;

  assign w_prod = $signed(i_data) * $signed(i_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sq  <= '0;
      o_vld <= 1'b0;
    end else if (i_clr) begin
      o_sq  <= '0;
      o_vld <= 1'b0;
    end else begin
      o_vld <= i_en;
      if (i_en) o_sq <= w_prod;
    end
  end

endmodule

// File: rtl/fixed_point_mean_square.sv
// -----------------------------------------------------------------------------
// fixed_point_mean_square
//   Streaming mean-square of blocks of 2^LOG2N signed WI.WF samples, emitted in
//   WOI.WOF format (saturated) for a downstream fixed-point square root.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   clr                : synchronous block abort (priority over handshakes)
//   in_valid/in_ready  : sample handshake, in_data signed WI+WF bits
//   out_valid/out_ready: result handshake, out_data WOI+WOF bits (>= 0)
//   upflow, downflow   : saturation / nonzero-rounded-to-zero, qualified by out_valid
//   out_peak           : max |in_data| of the block (only with
//                        FIXED_POINT_MEAN_SQUARE_PEAK_EN defined)
// -----------------------------------------------------------------------------
module fixed_point_mean_square
  import fixed_point_pkg::*;
#(
  parameter int unsigned WI    = 8,
  parameter int unsigned WF    = 8,
  parameter int unsigned WOI   = 9,
  parameter int unsigned WOF   = 10,
  parameter int unsigned LOG2N = 2,
  parameter int unsigned ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WI+WF-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WOI+WOF-1:0]   out_data,
  output logic                 upflow,
  output logic                 downflow
`ifdef FIXED_POINT_MEAN_SQUARE_PEAK_EN
  ,
  output logic [WI+WF-1:0]     out_peak
`endif
);

  localparam int unsigned W     = WI + WF;
  localparam int unsigned SQ_W  = 2 * W;
  localparam int unsigned ACC_W = acc_width(WI, WF, LOG2N);
  localparam int unsigned WO    = WOI + WOF;
  localparam int unsigned N     = 1 << LOG2N;

  state_t             r_state;
  logic [LOG2N:0]     r_cnt;
  logic [ACC_W-1:0]   r_acc;

  logic               w_accept;
  logic [SQ_W-1:0]    w_sq;
  logic               w_sq_vld;
  logic [ACC_W-1:0]   w_sum;
  rescale_t           w_conv;
  logic [WO-1:0]      w_out_data;
  logic [63-WO:0]     w_conv_unused_hi;

  assign in_ready = (r_state == ST_ACC);
  assign w_accept = in_valid && in_ready && !clr;

  fixed_point_square_reg #(
    .W (W)
  ) u_square (
    .clk    (clk),
    .rst_n  (rst),
    .i_clr  (clr),
    .i_en   (w_accept),
    .i_data (in_data),
    .o_sq   (w_sq),
    .o_vld  (w_sq_vld)
  );

  // During DRAIN the last square is still in stage 1, so the result is formed
  // from accumulator + pending square rather than waiting another cycle.
  assign w_sum  = r_acc + ACC_W'(w_sq);
  assign w_conv = sat_rescale(64'(w_sum), LOG2N, 2 * WF, WOI, WOF, (ROUND != 0));
  assign {w_conv_unused_hi, w_out_data} = w_conv.data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_ACC;
      r_cnt     <= '0;
      r_acc     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      upflow    <= 1'b0;
      downflow  <= 1'b0;
    end else if (clr) begin
      r_state   <= ST_ACC;
      r_cnt     <= '0;
      r_acc     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (w_sq_vld) r_acc <= w_sum;
      unique case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == (LOG2N + 1)'(N - 1)) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          out_data  <= w_out_data;
          upflow    <= w_conv.upflow;
          downflow  <= w_conv.downflow;
          out_valid <= 1'b1;
          r_state   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_state   <= ST_ACC;
          end
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end

`ifdef FIXED_POINT_MEAN_SQUARE_PEAK_EN
  logic [W-1:0] w_abs;
  logic [W-1:0] r_peak_run;

  // |most negative| has no positive representation; clamp to max positive.
  always_comb begin
    w_abs = in_data;
    if (in_data == {1'b1, {(W-1){1'b0}}}) w_abs = {1'b0, {(W-1){1'b1}}};
    else if (in_data[W-1])                w_abs = -in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_peak_run <= '0;
      out_peak   <= '0;
    end else if (clr) begin
      r_peak_run <= '0;
      out_peak   <= '0;
    end else begin
      if (w_accept && (w_abs > r_peak_run)) r_peak_run <= w_abs;
      if (r_state == ST_DRAIN)              out_peak   <= r_peak_run;
      if ((r_state == ST_HOLD) && out_ready) r_peak_run <= '0;
    end
  end
`endif

endmodule
